// File: rtl/ddr_rd_responder_if.sv
// Shared widths and the request/data/memory bundle of the DDR read responder.
// Ports (slave = responder side): request channel ddr_addr/ddr_size/ddr_addr_valid/ddr_addr_ready,
//   beat channel ddr_data/ddr_valid/ddr_ready, memory port mem_rd_en/mem_rd_addr/mem_rd_data, busy.
// The master modport is the environment: requester, beat consumer and backing memory together.

package GLOBAL_PARAM;
  parameter int DDR_W      = 32;
  parameter int DDR_ADDR_W = 16;
  parameter int BURST_W    = 8;
endpackage

interface ddr_rd_responder_if;
  import GLOBAL_PARAM::*;

  // request channel
  logic [DDR_ADDR_W-1:0] ddr_addr;
  logic [BURST_W-1:0]    ddr_size;
  logic                  ddr_addr_valid;
  logic                  ddr_addr_ready;
  // beat channel
  logic [DDR_W-1:0]      ddr_data;
  logic                  ddr_valid;
  logic                  ddr_ready;
  // backing memory, data returns one cycle after mem_rd_en
  logic                  mem_rd_en;
  logic [DDR_ADDR_W-1:0] mem_rd_addr;
  logic [DDR_W-1:0]      mem_rd_data;
  // activity status
  logic                  busy;

  modport master (
    output ddr_addr, ddr_size, ddr_addr_valid, ddr_ready, mem_rd_data,
    input  ddr_addr_ready, ddr_data, ddr_valid, mem_rd_en, mem_rd_addr, busy
  );

  modport slave (
    input  ddr_addr, ddr_size, ddr_addr_valid, ddr_ready, mem_rd_data,
    output ddr_addr_ready, ddr_data, ddr_valid, mem_rd_en, mem_rd_addr, busy
  );
endinterface

// File: rtl/ddr_rd_responder.sv
// Purpose: queues {addr,size} burst reads, walks each burst against a 1-cycle memory, returns beats in order.
// Latency: handshake in cycle T -> first mem_rd_en in T+1 -> first ddr_valid in T+3; 1 beat/cycle sustained.
// Backpressure: reads stall while buffered + in-flight beats would exceed OBUF_DEPTH; ddr_addr_ready = !queue_full (registered).
// Ports: clk, rst (synchronous, active-high); bus = ddr_rd_responder_if.slave carrying the request channel,
//   the beat channel, the backing memory read port and busy.
module ddr_rd_responder
  import GLOBAL_PARAM::*;
#(
  parameter int REQ_DEPTH  = 4,
  parameter int OBUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  ddr_rd_responder_if.slave   bus
);

  localparam int RA_W  = $clog2(REQ_DEPTH);
  localparam int OB_W  = $clog2(OBUF_DEPTH);
  localparam int OBC_W = $clog2(OBUF_DEPTH + 1);

  localparam logic [RA_W:0]      REQ_FULL  = (RA_W + 1)'(REQ_DEPTH);
  localparam logic [RA_W:0]      REQ_ONE   = (RA_W + 1)'(1);
  localparam logic [OB_W-1:0]    OB_LAST   = (OB_W)'(OBUF_DEPTH - 1);
  localparam logic [OB_W-1:0]    OB_ONE    = (OB_W)'(1);
  localparam logic [OBC_W-1:0]   OBC_ONE   = (OBC_W)'(1);
  localparam logic [OBC_W:0]     OB_LIM    = (OBC_W + 1)'(OBUF_DEPTH);
  localparam logic [BURST_W-1:0] BEAT_ONE  = (BURST_W)'(1);
  localparam logic [DDR_ADDR_W-1:0] ADDR_ONE = (DDR_ADDR_W)'(1);

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic [BURST_W-1:0]    size;
  } req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Request queue. Pointers carry one extra wrap bit so full/empty fall out of
  // the pointer difference. The queue is fall-through: when it is empty the
  // incoming request is presented as the head, so an idle engine can start a
  // burst on the accepting edge instead of a cycle later.
  // ---------------------------------------------------------------------------
  req_t            req_mem [REQ_DEPTH];
  logic [RA_W:0]   req_wr_ptr;
  logic [RA_W:0]   req_rd_ptr;
  logic [RA_W:0]   req_count;
  logic [RA_W:0]   req_count_nxt;
  logic            req_empty;
  logic            addr_ready_q;
  logic            req_push;
  logic            req_pop;
  logic            req_wr_en;
  logic            req_rd_adv;
  logic            head_vld;
  logic            head_go;
  req_t            head;
  req_t            in_req;

  // ---------------------------------------------------------------------------
  // Burst engine and output buffer state
  // ---------------------------------------------------------------------------
  state_t                state;
  logic [DDR_ADDR_W-1:0] cur_addr;
  logic [BURST_W-1:0]    remaining;
  logic                  inflight;
  logic                  issue;
  logic                  last_beat;

  logic [DDR_W-1:0]      ob_mem [OBUF_DEPTH];
  logic [OB_W-1:0]       ob_wr_ptr;
  logic [OB_W-1:0]       ob_rd_ptr;
  logic [OBC_W-1:0]      ob_count;
  logic [OBC_W:0]        ob_used;
  logic                  ob_vld;
  logic                  ob_deq;
  logic                  ob_cap;

  // ---------------------------------------------------------------------------
  // Request queue control
  // ---------------------------------------------------------------------------
  assign in_req.addr = bus.ddr_addr;
  assign in_req.size = bus.ddr_size;

  assign req_count = req_wr_ptr - req_rd_ptr;
  assign req_empty = (req_count == '0);
  assign req_push  = bus.ddr_addr_valid && addr_ready_q;

  assign head_vld  = !req_empty || req_push;
  assign head      = req_empty ? in_req : req_mem[req_rd_ptr[RA_W-1:0]];
  assign head_go   = head_vld && (head.size != '0);

  // A request consumed straight off the input never occupies a slot.
  assign req_wr_en  = req_push && !(req_empty && req_pop);
  assign req_rd_adv = req_pop && !req_empty;

  always_comb begin
    req_count_nxt = req_count;
    if (req_wr_en) begin
      req_count_nxt = req_count_nxt + REQ_ONE;
    end
    if (req_rd_adv) begin
      req_count_nxt = req_count_nxt - REQ_ONE;
    end
  end

  // ddr_addr_ready is a pure flop of the next occupancy, so a pop and a push
  // arriving together on a full queue cannot sneak the push in.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_wr_ptr   <= '0;
      req_rd_ptr   <= '0;
      addr_ready_q <= 1'b0;
    end else begin
      if (req_wr_en) begin
        req_wr_ptr <= req_wr_ptr + REQ_ONE;
      end
      if (req_rd_adv) begin
        req_rd_ptr <= req_rd_ptr + REQ_ONE;
      end
      addr_ready_q <= (req_count_nxt != REQ_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (req_wr_en) begin
      req_mem[req_wr_ptr[RA_W-1:0]] <= in_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Read credit. ob_used is the buffer occupancy once this cycle's in-flight
  // word lands and this cycle's accepted beat leaves; issuing only while it is
  // below OBUF_DEPTH guarantees every capture has a free slot. Counting the
  // departing beat is what lets a 2-entry buffer sustain one beat per cycle.
  // ---------------------------------------------------------------------------
  assign ob_vld  = (ob_count != '0);
  assign ob_deq  = ob_vld && bus.ddr_ready;
  assign ob_cap  = inflight;
  assign ob_used = {1'b0, ob_count} + (OBC_W + 1)'(inflight) - (OBC_W + 1)'(ob_deq);

  assign issue     = (state == BURST) && (ob_used < OB_LIM);
  assign last_beat = issue && (remaining == BEAT_ONE);

  // Idle engine always drains the head (zero-size requests are just dropped);
  // a busy engine takes the next non-empty burst on its last issue.
  assign req_pop = ((state == IDLE) && head_vld) || (last_beat && head_go);

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (head_go) begin
            state     <= BURST;
            cur_addr  <= head.addr;
            remaining <= head.size;
          end
        end
        BURST: begin
          if (issue) begin
            if (remaining == BEAT_ONE) begin
              if (head_go) begin
                // chain straight into the next burst, no idle cycle
                cur_addr  <= head.addr;
                remaining <= head.size;
              end else begin
                state     <= IDLE;
                cur_addr  <= cur_addr + ADDR_ONE;
                remaining <= '0;
              end
            end else begin
              // address wraps modulo 2^DDR_ADDR_W
              cur_addr  <= cur_addr + ADDR_ONE;
              remaining <= remaining - BEAT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One read at most per cycle, so a single bit tracks the memory return.
  // Clearing it in reset drops a return belonging to an aborted burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ob_wr_ptr <= '0;
      ob_rd_ptr <= '0;
      ob_count  <= '0;
    end else begin
      if (ob_cap) begin
        ob_wr_ptr <= (ob_wr_ptr == OB_LAST) ? '0 : ob_wr_ptr + OB_ONE;
      end
      if (ob_deq) begin
        ob_rd_ptr <= (ob_rd_ptr == OB_LAST) ? '0 : ob_rd_ptr + OB_ONE;
      end
      case ({ob_cap, ob_deq})
        2'b10:   ob_count <= ob_count + OBC_ONE;
        2'b01:   ob_count <= ob_count - OBC_ONE;
        default: ob_count <= ob_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ob_cap) begin
      ob_mem[ob_wr_ptr] <= bus.mem_rd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ddr_addr_ready = addr_ready_q;
  assign bus.ddr_valid      = ob_vld;
  assign bus.ddr_data       = ob_vld ? ob_mem[ob_rd_ptr] : '0;
  assign bus.mem_rd_en      = issue;
  assign bus.mem_rd_addr    = cur_addr;
  assign bus.busy           = !req_empty || (state == BURST) || inflight || ob_vld;

endmodule

// File: tb/tb_ddr_rd_responder.sv
// Directed bench for ddr_rd_responder: memory model returns word = address one cycle after each read.
// Stimulus is driven 1 time unit after the rising edge; the monitor samples on the falling edge.
// Summary line reports total comparisons and mismatches.
module tb_ddr_rd_responder;
  import GLOBAL_PARAM::*;

  logic clk;
  logic rst;
  ddr_rd_responder_if bus ();

  ddr_rd_responder #(.REQ_DEPTH(4), .OBUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // backing memory: data equals zero-extended address, garbage when not read
  always @(posedge clk) begin
    bus.mem_rd_data <= bus.mem_rd_en ? {(DDR_W - DDR_ADDR_W)'(0), bus.mem_rd_addr} : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              mon_clr = 1'b0;
  logic [31:0]       beat_q[$];
  int                beat_cyc_q[$];
  logic [15:0]       rd_addr_q[$];
  int                rd_cyc_q[$];
  int                hs_cyc, hs_cnt, first_vld, last_busy;
  int                max_out, unstable, rd_total, acc_total;
  logic              prev_stall = 1'b0;
  logic [31:0]       prev_data = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      beat_q.delete(); beat_cyc_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
      hs_cyc = -1; hs_cnt = 0; first_vld = -1; last_busy = -1;
      max_out = 0; unstable = 0; rd_total = 0; acc_total = 0;
    end
    if (prev_stall && !rst && (!bus.ddr_valid || bus.ddr_data !== prev_data)) unstable++;
    if (rd_total - acc_total > max_out) max_out = rd_total - acc_total;
    if (bus.mem_rd_en) begin
      rd_addr_q.push_back(bus.mem_rd_addr);
      rd_cyc_q.push_back(cyc);
      rd_total++;
    end
    if (bus.ddr_valid && first_vld < 0) first_vld = cyc;
    if (bus.ddr_valid && bus.ddr_ready) begin
      beat_q.push_back(bus.ddr_data);
      beat_cyc_q.push_back(cyc);
      acc_total++;
    end
    if (bus.ddr_addr_valid && bus.ddr_addr_ready) begin
      hs_cyc = cyc;
      hs_cnt++;
    end
    if (bus.busy) last_busy = cyc;
    prev_stall = bus.ddr_valid && !bus.ddr_ready;
    prev_data  = bus.ddr_data;
  end

  // ---------------------------------------------------------------------------
  // Helpers (all called at 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_req(input logic [15:0] a, input logic [7:0] s);
    int n = 0;
    bus.ddr_addr = a;
    bus.ddr_size = s;
    bus.ddr_addr_valid = 1'b1;
    @(negedge clk);
    while (!bus.ddr_addr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.ddr_addr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_beats(input string tag, input logic [31:0] exp [$]);
    chk({tag, "_count"}, 32'(beat_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("%s_beat%0d", tag, i), (i < beat_q.size()) ? beat_q[i] : 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          nv;
  int          hs;

  initial begin
    rst = 1'b1;
    bus.ddr_addr = '0;
    bus.ddr_size = '0;
    bus.ddr_addr_valid = 1'b0;
    bus.ddr_ready = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ready", 32'(bus.ddr_addr_ready), 32'd0);
    chk("rst_valid",      32'(bus.ddr_valid),      32'd0);
    chk("rst_mem_rd_en",  32'(bus.mem_rd_en),      32'd0);
    chk("rst_busy",       32'(bus.busy),           32'd0);
    chk("rst_data",       bus.ddr_data,            32'd0);
    chk("rst_rd_addr",    32'(bus.mem_rd_addr),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready_first", 32'(bus.ddr_addr_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready_next",  32'(bus.ddr_addr_ready), 32'd1);
    @(posedge clk); #1;

    // single burst (0x100,4): latency and throughput
    mon_clear();
    push_req(16'h0100, 8'd4);
    wait_idle();
    hs = hs_cyc;
    exp_q = {32'h100, 32'h101, 32'h102, 32'h103};
    chk_beats("single", exp_q);
    chk("single_rd_lat",  32'(rd_cyc_q[0] - hs), 32'd1);
    chk("single_vld_lat", 32'(first_vld - hs),    32'd3);
    for (int i = 0; i < 4; i++)
      chk($sformatf("single_beat_cyc%0d", i), 32'(beat_cyc_q[i] - hs), 32'(3 + i));
    chk("single_busy_fall", 32'(last_busy - hs), 32'd6);

    // back-to-back bursts with no gap in reads
    mon_clear();
    push_req(16'h0010, 8'd2);
    push_req(16'h0020, 8'd3);
    wait_idle();
    exp_q = {32'h10, 32'h11, 32'h20, 32'h21, 32'h22};
    chk_beats("b2b", exp_q);
    chk("b2b_rd_count", 32'(rd_cyc_q.size()), 32'd5);
    chk("b2b_rd_span",  32'(rd_cyc_q[4] - rd_cyc_q[0]), 32'd4);

    // backpressure: ready toggles every cycle
    mon_clear();
    push_req(16'h0500, 8'd8);
    for (int i = 0; i < 80 && beat_q.size() < 8; i++) begin
      @(posedge clk); #1;
      bus.ddr_ready = ~bus.ddr_ready;
    end
    bus.ddr_ready = 1'b1;
    wait_idle();
    exp_q = {32'h500, 32'h501, 32'h502, 32'h503, 32'h504, 32'h505, 32'h506, 32'h507};
    chk_beats("bp", exp_q);
    chk("bp_outstanding_le2", 32'(max_out <= 2), 32'd1);
    chk("bp_stable",          32'(unstable),     32'd0);

    // full queue while the engine is stalled, plus address wrap
    mon_clear();
    bus.ddr_ready = 1'b0;
    push_req(16'h0300, 8'd4);
    push_req(16'h0400, 8'd1);
    push_req(16'h0410, 8'd2);
    push_req(16'hFFFE, 8'd3);
    push_req(16'h0420, 8'd1);
    bus.ddr_addr = 16'h0430;
    bus.ddr_size = 8'd2;
    bus.ddr_addr_valid = 1'b1;
    @(negedge clk);
    chk("full_ready_low", 32'(bus.ddr_addr_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("full_refused", 32'(hs_cnt), 32'd5);
    @(posedge clk); #1;
    bus.ddr_ready = 1'b1;
    push_req(16'h0430, 8'd2);
    wait_idle();
    exp_q = {32'h300, 32'h301, 32'h302, 32'h303, 32'h400, 32'h410, 32'h411,
             32'hFFFE, 32'hFFFF, 32'h0, 32'h420, 32'h430, 32'h431};
    chk_beats("full", exp_q);
    chk("wrap_rd0", 32'(rd_addr_q[7]), 32'hFFFE);
    chk("wrap_rd1", 32'(rd_addr_q[8]), 32'hFFFF);
    chk("wrap_rd2", 32'(rd_addr_q[9]), 32'h0000);

    // zero-size request produces nothing
    mon_clear();
    push_req(16'h0040, 8'd0);
    push_req(16'h0050, 8'd1);
    wait_idle();
    exp_q = {32'h50};
    chk_beats("zero", exp_q);
    chk("zero_rd_count", 32'(rd_addr_q.size()), 32'd1);

    // reset during the second beat of a 6-beat burst
    mon_clear();
    push_req(16'h0600, 8'd6);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_valid",      32'(bus.ddr_valid),      32'd0);
    chk("mid_rst_mem_rd_en",  32'(bus.mem_rd_en),      32'd0);
    chk("mid_rst_busy",       32'(bus.busy),           32'd0);
    chk("mid_rst_addr_ready", 32'(bus.ddr_addr_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ddr_valid) nv++;
      if (i == 0) chk("mid_rel_ready_first", 32'(bus.ddr_addr_ready), 32'd0);
      if (i == 1) chk("mid_rel_ready_next",  32'(bus.ddr_addr_ready), 32'd1);
    end
    chk("mid_rel_no_valid", 32'(nv), 32'd0);
    exp_q = {32'h600, 32'h601};
    chk_beats("mid", exp_q);
    @(posedge clk); #1;

    // recovery after reset
    mon_clear();
    push_req(16'h0700, 8'd2);
    wait_idle();
    exp_q = {32'h700, 32'h701};
    chk_beats("recover", exp_q);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
